// File: rtl/nested_loop_index_gen.sv
// Sequential outer/inner loop walker streaming (i, j) pairs over valid/ready.
// Define NESTED_LOOP_SKIP_EN to suppress pair (1, 1) with continue semantics.
//
// state | meaning
// IDLE  | waiting for in_start, limits and count held
// RUN   | presenting pairs, advancing on handshake or skip cycle
// DONE  | one-cycle out_done pulse, then back to IDLE
module nested_loop_index_gen #(
    parameter int W  = 2,
    parameter int CW = 2 * W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_start,
    input  logic [W-1:0]  in_outer_limit,
    input  logic [W-1:0]  in_inner_limit,
    output logic          out_busy,
    output logic          out_valid,
    input  logic          in_ready,
    output logic [W-1:0]  out_i,
    output logic [W-1:0]  out_j,
    output logic [CW-1:0] out_count,
    output logic          out_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    rst_sync;
    logic          rst_int_n;
    logic [1:0]    state;
    logic [W-1:0]  i_q;
    logic [W-1:0]  j_q;
    logic [W-1:0]  lim_outer;
    logic [W-1:0]  lim_inner;
    logic [CW-1:0] count_q;
    logic          skip;
    logic          handshake;
    logic          advance;
    logic          j_wrap;
    logic          last_pair;

    // Assertion reaches the core at once; release is retimed to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

`ifdef NESTED_LOOP_SKIP_EN
    assign skip = (state == RUN) && (i_q == W'(1)) && (j_q == W'(1));
`else
    assign skip = 1'b0;
`endif

    assign out_valid = (state == RUN) && !skip;
    assign out_busy  = (state == RUN);
    assign out_done  = (state == DONE);
    assign out_i     = i_q;
    assign out_j     = j_q;
    assign out_count = count_q;

    assign handshake = out_valid && in_ready;
    assign advance   = (state == RUN) && (handshake || skip);

    // Compares widened by one bit so a limit of 2^W-1 cannot wrap.
    assign j_wrap    = ({1'b0, j_q} == {1'b0, lim_inner});
    assign last_pair = j_wrap && (({1'b0, i_q} + (W+1)'(1)) == {1'b0, lim_outer});

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            i_q       <= '0;
            j_q       <= W'(1);
            lim_outer <= '0;
            lim_inner <= '0;
            count_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_start) begin
                        lim_outer <= in_outer_limit;
                        lim_inner <= in_inner_limit;
                        count_q   <= '0;
                        i_q       <= '0;
                        j_q       <= W'(1);
                        if ((in_outer_limit == '0) || (in_inner_limit == '0)) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        count_q <= count_q + CW'(1);
                    end
                    if (advance) begin
                        if (last_pair) begin
                            state <= DONE;
                        end else if (j_wrap) begin
                            j_q <= W'(1);
                            i_q <= i_q + W'(1);
                        end else begin
                            j_q <= j_q + W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nested_loop_index_gen.sv
// Self-checking bench for nested_loop_index_gen: vector table plus scoreboard queue.
// Honours NESTED_LOOP_SKIP_EN when computing expected pair streams.
module tb_nested_loop_index_gen;

    localparam int W  = 2;
    localparam int CW = 2 * W;

`ifdef NESTED_LOOP_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_start;
    logic [W-1:0]  in_outer_limit;
    logic [W-1:0]  in_inner_limit;
    logic          out_busy;
    logic          out_valid;
    logic          in_ready;
    logic [W-1:0]  out_i;
    logic [W-1:0]  out_j;
    logic [CW-1:0] out_count;
    logic          out_done;

    nested_loop_index_gen #(.W(W), .CW(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_start       (in_start),
        .in_outer_limit (in_outer_limit),
        .in_inner_limit (in_inner_limit),
        .out_busy       (out_busy),
        .out_valid      (out_valid),
        .in_ready       (in_ready),
        .out_i          (out_i),
        .out_j          (out_j),
        .out_count      (out_count),
        .out_done       (out_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int outer;
        int inner;
        int stall;
        int exp_count;
    } vec_t;

    typedef struct {
        int i;
        int j;
    } pair_t;

    int    checks;
    int    failures;
    pair_t exp_q[$];
    vec_t  vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drives one loop nest, scoreboards every handshaken pair, checks timing and count.
    task automatic run_nest(input int outer, input int inner, input int stall,
                            input int exp_count, input string name);
        int    emitted;
        int    nskip;
        int    cyc;
        int    stall_cnt;
        int    done_cyc;
        pair_t p;
        emitted = 0;
        nskip   = 0;
        for (int i = 0; i < outer; i++) begin
            for (int j = 1; j <= inner; j++) begin
                if (SKIP_EN && i == 1 && j == 1) begin
                    nskip++;
                end else begin
                    p.i = i;
                    p.j = j;
                    exp_q.push_back(p);
                    emitted++;
                end
            end
        end
        @(negedge clk);
        in_start       = 1'b1;
        in_outer_limit = W'(outer);
        in_inner_limit = W'(inner);
        in_ready       = (stall == 0);
        @(negedge clk);
        in_start  = 1'b0;
        cyc       = 1;
        stall_cnt = 0;
        done_cyc  = -1;
        while (cyc <= 200) begin
            if (out_done) begin
                done_cyc = cyc;
                check({name, " valid_in_done"}, int'(out_valid), 0);
                break;
            end
            check({name, " busy"}, int'(out_busy), 1);
            // A start while running must be ignored.
            if (cyc == 1) begin
                in_start       = 1'b1;
                in_outer_limit = W'(3);
                in_inner_limit = W'(3);
            end else begin
                in_start = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check({name, " extra_pair"}, 1, 0);
                end else begin
                    check({name, " i"}, int'(out_i), exp_q[0].i);
                    check({name, " j"}, int'(out_j), exp_q[0].j);
                end
                if (stall_cnt < stall) begin
                    in_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    in_ready  = 1'b1;
                    stall_cnt = 0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end else begin
                in_ready = (stall == 0);
            end
            @(negedge clk);
            cyc++;
        end
        in_start = 1'b0;
        if (done_cyc < 0) begin
            failures++;
            checks++;
            $display("FAIL %s timeout: no out_done within 200 cycles", name);
        end
        check({name, " done_cycle"}, done_cyc, emitted * (stall + 1) + nskip + 1);
        check({name, " pairs_left"}, exp_q.size(), 0);
        check({name, " count"}, int'(out_count), exp_count);
        exp_q.delete();
        @(negedge clk);
        check({name, " done_pulse_width"}, int'(out_done), 0);
        check({name, " busy_after"}, int'(out_busy), 0);
        check({name, " count_hold"}, int'(out_count), exp_count);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " busy"},  int'(out_busy), 0);
        check({name, " valid"}, int'(out_valid), 0);
        check({name, " done"},  int'(out_done), 0);
        check({name, " i"},     int'(out_i), 0);
        check({name, " j"},     int'(out_j), 1);
        check({name, " count"}, int'(out_count), 0);
    endtask

    initial begin
        vec_t v;
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        in_start       = 1'b0;
        in_outer_limit = '0;
        in_inner_limit = '0;
        in_ready       = 1'b1;

        v = '{2, 2, 0, SKIP_EN ? 3 : 4}; vecs.push_back(v);
        v = '{3, 3, 0, SKIP_EN ? 8 : 9}; vecs.push_back(v);
        v = '{2, 2, 3, SKIP_EN ? 3 : 4}; vecs.push_back(v);
        v = '{0, 3, 0, 0};               vecs.push_back(v);
        v = '{3, 0, 0, 0};               vecs.push_back(v);
        v = '{1, 3, 0, 3};               vecs.push_back(v);
        v = '{3, 2, 1, SKIP_EN ? 5 : 6}; vecs.push_back(v);
        v = '{3, 3, 2, SKIP_EN ? 8 : 9}; vecs.push_back(v);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_values("reset");

        for (int k = 0; k < vecs.size(); k++) begin
            run_nest(vecs[k].outer, vecs[k].inner, vecs[k].stall, vecs[k].exp_count,
                     $sformatf("vec%0d_%0dx%0d_s%0d", k, vecs[k].outer, vecs[k].inner,
                               vecs[k].stall));
        end

        // Reset after the second handshake of a 3x3 run.
        @(negedge clk);
        in_start       = 1'b1;
        in_outer_limit = W'(3);
        in_inner_limit = W'(3);
        in_ready       = 1'b1;
        @(negedge clk);
        in_start = 1'b0;
        check("midrst pair0_j", int'(out_j), 1);
        @(negedge clk);
        check("midrst pair1_j", int'(out_j), 2);
        @(negedge clk);
        check("midrst before_rst_count", int'(out_count), 2);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_values("midrst_idle");
        run_nest(1, 1, 0, 1, "after_rst_1x1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nested_loop_index_gen.md
Name: nested_loop_index_gen

Overview:
- Sequential counterpart of the combinational nested-loop counter.
- Walks an outer/inner loop nest over clock cycles and streams each surviving (i, j) index pair to a consumer over a valid/ready handshake.
- Reports the final pair count, which equals the count produced by the combinational counter for the same limits.
- Sits between a limit-issuing controller (start handshake) and a downstream index consumer.

Parameters:
- W, 2, width of loop limits and indices.
- CW, 2*W, width of out_count.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_start  input  1  one-cycle request to begin a loop nest; sampled only in IDLE.
- in_outer_limit  input  W  outer loop limit; latched on accepted start.
- in_inner_limit  input  W  inner loop limit; latched on accepted start.
- out_busy  output  1  high in RUN.
- out_valid  output  1  current index pair is valid.
- in_ready  input  1  consumer accepts the pair.
- out_i  output  W  outer index, range 0..outer_limit-1.
- out_j  output  W  inner index, post-increment value, range 1..inner_limit.
- out_count  output  CW  number of pairs handshaken in the current or last run.
- out_done  output  1  one-cycle pulse at the end of a run.

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE; out_busy, out_valid and out_done = 0; out_i = 0; out_j = 1; out_count = 0; latched limits = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_start=1 latches both limits and clears out_count.
  - Either limit == 0 -> DONE next cycle; otherwise -> RUN with i=0, j=1.
  - in_start while not IDLE is ignored.
- RUN:
  - Pair (i, j) is presented with out_valid=1, except the skip pair (see Optional Feature).
  - out_i/out_j are held stable while out_valid=1 and in_ready=0.
  - out_valid is never withdrawn without a handshake.
  - Advance on handshake (out_valid & in_ready), or unconditionally in a skip cycle:
    - j == inner_limit -> j=1, i=i+1; otherwise j=j+1.
    - Last pair (i == outer_limit-1, j == inner_limit) -> DONE.
  - out_count increments by 1 on each handshake only; skip cycles do not count.
  - Latency: first pair is valid 1 cycle after the accepted start. With in_ready tied high, throughput is 1 pair/cycle, and a skip costs one bubble cycle.
- DONE: out_done=1 for exactly one cycle, out_valid=0, then -> IDLE. out_count holds until the next accepted start.
- Arithmetic:
  - Index compare and advance are done in W+1 bits, so limit = 2^W-1 does not wrap.
  - out_count is sized CW so the maximum (2^W-1)^2 never overflows.
- Reset mid-run: all outputs return to reset values immediately and the in-flight pair is dropped.

Optional Feature:
- Macro: NESTED_LOOP_SKIP_EN.
- Defined:
  - Pair (i=1, j=1) is suppressed, giving continue semantics.
  - That cycle has out_valid=0 and is not counted.
  - Final count = outer_limit*inner_limit - (outer_limit>1 ? 1 : 0).
- Undefined: every pair is emitted; final count = outer_limit*inner_limit.

Test Plan:
- SKIP_EN defined, outer=2, inner=2, in_ready=1:
  - pairs (0,1),(0,2),(1,2) on cycles 1, 2, 4; cycle 3 has out_valid=0.
  - out_done pulses on cycle 5; out_count=3.
- SKIP_EN defined, outer=3, inner=3, in_ready=1 -> 8 pairs, out_count=8, (1,1) never emitted.
- SKIP_EN undefined, outer=2, inner=2 -> pairs (0,1),(0,2),(1,1),(1,2), out_count=4.
- Backpressure: outer=2, inner=2, in_ready low for 3 cycles on each pair -> out_i/out_j stable while stalled, same pair sequence and count as the unstalled run, out_busy high throughout.
- outer=0, inner=3 (then outer=3, inner=0) -> no out_valid; out_done exactly 1 cycle after start; out_count=0.
- Reset mid-run: rst_n low after the second handshake of a 3x3 run -> outputs at reset values immediately; a new 1x1 run afterwards gives pair (0,1), out_count=1.
